// File: rtl/eject_pkg.sv
// eject_pkg: shared VC index type, default drain/target constants and the
// log-line format used by eject_vc_sink.
package eject_pkg;

    // Widened VC index used for all VC comparisons inside the sink.
    localparam int VC_IDX_W = 8;
    typedef logic [VC_IDX_W-1:0] vc_idx_t;

    // Default drain timing and completion target.
    localparam int DEF_DRAIN_PERIOD = 16;
    localparam int DEF_DRAIN_ON     = 2;
    localparam int DEF_TARGET_CNT   = 990;

    // One line per popped flit: "<vc> <data in binary>".
    localparam string LOG_FMT = "%0d %b\n";

    // Index width for n items, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/SyncFIFO_RTL.sv
// SyncFIFO_RTL: single-clock FIFO, power-of-two depth. With FWFT=1 the head
// entry is presented on rd_data as soon as it is written; with FWFT=0 the
// head is registered on a read.
module SyncFIFO_RTL #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 4,
    parameter int DEPTH_LOG = 2,
    parameter int FWFT      = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    typedef logic [DEPTH_LOG-1:0] ptr_t;
    typedef logic [DEPTH_LOG:0]   cnt_t;

    localparam cnt_t CNT_FULL = cnt_t'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    ptr_t             wr_ptr;
    ptr_t             rd_ptr;
    cnt_t             count;
    logic             do_wr;
    logic             do_rd;

    assign full  = (count == CNT_FULL);
    assign empty = (count == '0);
    assign do_wr = wr_en & ~full;
    assign do_rd = rd_en & ~empty;

    // Storage write; contents need no reset because pointers define validity.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    if (FWFT != 0) begin : g_fwft
        assign rd_data = mem[rd_ptr];
    end else begin : g_registered
        logic [WIDTH-1:0] rd_data_q;

        // Registered read: head is captured when it is popped.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                rd_data_q <= '0;
            end else if (do_rd) begin
                rd_data_q <= mem[rd_ptr];
            end
        end

        assign rd_data = rd_data_q;
    end

endmodule

// File: rtl/eject_rr_arb.sv
// eject_rr_arb: N-way round-robin arbiter. The pointer names the highest
// priority requester; after a grant it moves to winner+1, otherwise it holds.
module eject_rr_arb
    import eject_pkg::*;
#(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [N-1:0] req,
    input  logic         en,
    output logic [N-1:0] gnt
);

    localparam int PW = clog2_min1(N);
    typedef logic [PW-1:0] ptr_t;
    localparam ptr_t LAST = ptr_t'(N - 1);

    ptr_t         ptr;
    ptr_t         ptr_next;
    ptr_t         win;
    logic         found;
    logic [N-1:0] masked_req;
    logic [N-1:0] pick;

    // Winner search: first requester at or above the pointer, else the
    // lowest requester overall (wrap-around).
    always_comb begin
        masked_req = req & ({N{1'b1}} << ptr);
        pick       = '0;
        win        = ptr;
        found      = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (!found && masked_req[j]) begin
                found   = 1'b1;
                win     = ptr_t'(j);
                pick[j] = 1'b1;
            end
        end
        for (int j = 0; j < N; j++) begin
            if (!found && req[j]) begin
                found   = 1'b1;
                win     = ptr_t'(j);
                pick[j] = 1'b1;
            end
        end
        gnt      = en ? pick : '0;
        ptr_next = ptr;
        if (en && found) begin
            ptr_next = (win == LAST) ? '0 : win + 1'b1;
        end
    end

    // Priority pointer register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_next;
        end
    end

endmodule

// File: rtl/eject_vc_sink.sv
// eject_vc_sink: multi-VC ejection sink for a router local output port.
// Flits are buffered per VC, drained one per cycle during the drain window of
// a free-running phase counter, and each pop returns a one-cycle credit.
// Optional build macro: EJECT_LOG_EN (simulation-only pop logger).
//
// Handshake: a flit is accepted at a rising edge when valid is high, vc_id
// is below NUM_VC and ready[vc_id] is high. ready[v] reflects only the
// buffer's full flag, so a pop in the same cycle never re-opens a full VC.
// A valid flit that is not accepted is discarded and raises drop_err.
module eject_vc_sink
    import eject_pkg::*;
#(
    parameter int DW           = 32,
    parameter int NUM_VC       = 2,
    parameter int DEPTH        = 4,
    parameter int DEPTH_LOG    = 2,
    parameter int DRAIN_PERIOD = DEF_DRAIN_PERIOD,
    parameter int DRAIN_ON     = DEF_DRAIN_ON,
    parameter int TARGET_CNT   = DEF_TARGET_CNT,
    parameter     ID           = "0"
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            valid,
    input  logic [clog2_min1(NUM_VC)-1:0]   vc_id,
    input  logic [DW-1:0]                   data,
    output logic [NUM_VC-1:0]               ready,
    output logic [NUM_VC-1:0]               credit_upd,
    output logic [31:0]                     eject_cnt,
    output logic                            done,
    output logic                            drop_err
);

    localparam int PHW = clog2_min1(DRAIN_PERIOD);
    typedef logic [PHW-1:0] phase_t;
    localparam phase_t      PHASE_LAST = phase_t'(DRAIN_PERIOD - 1);
    localparam logic [31:0] TARGET     = 32'(TARGET_CNT);
    localparam int          ID_BITS    = $bits(ID);
    localparam bit          PARAM_OK   = (NUM_VC >= 1) && (DRAIN_PERIOD >= 1) &&
                                         (DRAIN_ON >= 1) && (DRAIN_ON <= DRAIN_PERIOD) &&
                                         (DEPTH_LOG >= 1) && (DEPTH == (1 << DEPTH_LOG)) &&
                                         (NUM_VC <= (1 << VC_IDX_W)) && (ID_BITS >= 8);

    if (!PARAM_OK) begin : g_param_check
        $error("eject_vc_sink: illegal parameter combination");
    end

    phase_t           phase;
    logic             drain_win;
    logic [NUM_VC-1:0] wr_en;
    logic [NUM_VC-1:0] full;
    logic [NUM_VC-1:0] empty;
    logic [NUM_VC-1:0] req;
    logic [NUM_VC-1:0] gnt;
    logic [DW-1:0]    rd_data [NUM_VC];
    logic             pop;
    logic             drop;
    logic [31:0]      cnt_q;
    logic [31:0]      cnt_inc;
    logic             done_q;
    logic             drop_q;

    // Free-running drain phase, wraps after DRAIN_PERIOD cycles.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            phase <= '0;
        end else if (phase == PHASE_LAST) begin
            phase <= '0;
        end else begin
            phase <= phase + 1'b1;
        end
    end

    if (DRAIN_ON >= DRAIN_PERIOD) begin : g_drain_always
        assign drain_win = 1'b1;
    end else begin : g_drain_window
        localparam phase_t WIN_START = phase_t'(DRAIN_PERIOD - DRAIN_ON);
        assign drain_win = (phase >= WIN_START);
    end

    // Per-VC FWFT buffers; a write happens only to a matching, non-full VC.
    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        assign wr_en[v] = valid & (vc_idx_t'(vc_id) == vc_idx_t'(v)) & ~full[v];

        SyncFIFO_RTL #(
            .WIDTH     (DW),
            .DEPTH     (DEPTH),
            .DEPTH_LOG (DEPTH_LOG),
            .FWFT      (1)
        ) u_fifo (
            .clk     (clk),
            .rstn    (rstn),
            .wr_en   (wr_en[v]),
            .wr_data (data),
            .rd_en   (gnt[v]),
            .rd_data (rd_data[v]),
            .full    (full[v]),
            .empty   (empty[v])
        );
    end

    assign req = ~empty;

    eject_rr_arb #(
        .N (NUM_VC)
    ) u_arb (
        .clk  (clk),
        .rstn (rstn),
        .req  (req),
        .en   (drain_win),
        .gnt  (gnt)
    );

    assign pop     = |gnt;
    assign drop    = valid & ~(|wr_en);
    assign cnt_inc = cnt_q + 32'd1;

    // Ejected-flit counter (saturating) and sticky completion flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else if (pop && (cnt_q != '1)) begin
            cnt_q <= cnt_inc;
            if (cnt_inc == TARGET) begin
                done_q <= 1'b1;
            end
        end
    end

    // Sticky drop flag: any valid flit that was not written anywhere.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            drop_q <= 1'b0;
        end else if (drop) begin
            drop_q <= 1'b1;
        end
    end

    assign ready      = ~full;
    assign credit_upd = gnt;
    assign eject_cnt  = cnt_q;
    assign done       = done_q;
    assign drop_err   = drop_q;

`ifdef EJECT_LOG_EN
    // One log line per popped flit.
    always @(posedge clk) begin
        for (int v = 0; v < NUM_VC; v++) begin
            if (rstn && gnt[v]) begin
                $display("receive_pool_%0s: %0d %b", ID, v, rd_data[v]);
            end
        end
    end

    // Let the network settle after completion, then stop.
    always @(posedge done_q) begin
        #25000;
        $stop;
    end
`else
    logic unused_pop_data;

    // Popped payload has no consumer without the logger.
    always_comb begin
        unused_pop_data = 1'b0;
        for (int v = 0; v < NUM_VC; v++) begin
            unused_pop_data = unused_pop_data ^ (^rd_data[v]);
        end
    end
`endif

endmodule

// File: tb/tb_eject_vc_sink.sv
// tb_eject_vc_sink: directed bench for eject_vc_sink. Instance a: 2 VCs,
// 2-of-16 drain window, target 10. Instance b: 3 VCs, drain every cycle.
`timescale 1ns/1ps
module tb_eject_vc_sink;

    logic        clk;
    logic        rstn;

    logic        a_valid;
    logic [0:0]  a_vc;
    logic [31:0] a_data;
    logic [1:0]  a_ready;
    logic [1:0]  a_credit;
    logic [31:0] a_cnt;
    logic        a_done;
    logic        a_drop;

    logic        b_valid;
    logic [1:0]  b_vc;
    logic [31:0] b_data;
    logic [2:0]  b_ready;
    logic [2:0]  b_credit;
    logic [31:0] b_cnt;
    logic        b_done;
    logic        b_drop;

    int total;
    int bad;

    logic [1:0] exp_q_a[$];
    logic [2:0] exp_q_b[$];

    eject_vc_sink #(
        .DW(32), .NUM_VC(2), .DEPTH(4), .DEPTH_LOG(2),
        .DRAIN_PERIOD(16), .DRAIN_ON(2), .TARGET_CNT(10), .ID("0")
    ) dut_a (
        .clk(clk), .rstn(rstn), .valid(a_valid), .vc_id(a_vc), .data(a_data),
        .ready(a_ready), .credit_upd(a_credit), .eject_cnt(a_cnt),
        .done(a_done), .drop_err(a_drop)
    );

    eject_vc_sink #(
        .DW(32), .NUM_VC(3), .DEPTH(4), .DEPTH_LOG(2),
        .DRAIN_PERIOD(16), .DRAIN_ON(16), .TARGET_CNT(990), .ID("1")
    ) dut_b (
        .clk(clk), .rstn(rstn), .valid(b_valid), .vc_id(b_vc), .data(b_data),
        .ready(b_ready), .credit_upd(b_credit), .eject_cnt(b_cnt),
        .done(b_done), .drop_err(b_drop)
    );

    // Clock and initial input state.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reset both instances; returns in the cycle where phase is 0.
    task automatic do_reset;
        rstn    = 1'b0;
        a_valid = 1'b0; a_vc = '0; a_data = '0;
        b_valid = 1'b0; b_vc = '0; b_data = '0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic test_reset_values;
        do_reset();
        total++; if (a_ready !== 2'b11) begin bad++; $display("FAIL rst_a_ready: got %b want 11", a_ready); end
        total++; if (a_credit !== 2'b00) begin bad++; $display("FAIL rst_a_credit: got %b want 00", a_credit); end
        total++; if (a_cnt !== 32'd0) begin bad++; $display("FAIL rst_a_cnt: got %0d want 0", a_cnt); end
        total++; if ({a_done, a_drop} !== 2'b00) begin bad++; $display("FAIL rst_a_flags: got %b want 00", {a_done, a_drop}); end
        total++; if (b_ready !== 3'b111) begin bad++; $display("FAIL rst_b_ready: got %b want 111", b_ready); end
        total++; if (b_credit !== 3'b000) begin bad++; $display("FAIL rst_b_credit: got %b want 000", b_credit); end
        total++; if ({b_done, b_drop, b_cnt} !== 34'd0) begin bad++; $display("FAIL rst_b_state: got %0d/%b%b want 0/00", b_cnt, b_done, b_drop); end
    endtask

    task automatic test_single_flit;
        int early;
        do_reset();
        a_valid = 1'b1; a_vc = 1'b1; a_data = 32'hA5A5A5A5;
        tick();
        a_valid = 1'b0;
        early = 0;
        for (int p = 1; p < 14; p++) begin
            if (a_credit !== 2'b00) early++;
            tick();
        end
        total++; if (early != 0) begin bad++; $display("FAIL single_early_credit: got %0d cycles want 0", early); end
        total++; if (a_credit !== 2'b10) begin bad++; $display("FAIL single_credit_ph14: got %b want 10", a_credit); end
        tick();
        total++; if (a_cnt !== 32'd1) begin bad++; $display("FAIL single_cnt: got %0d want 1", a_cnt); end
        total++; if (a_credit !== 2'b00) begin bad++; $display("FAIL single_credit_ph15: got %b want 00", a_credit); end
    endtask

    // Continues from test_single_flit: phase 15, eject_cnt 1.
    task automatic test_reset_mid_burst;
        int seen;
        for (int k = 0; k < 3; k++) begin
            a_valid = 1'b1; a_vc = 1'b0; a_data = 32'h100 + k;
            tick();
        end
        total++; if (a_cnt !== 32'd1) begin bad++; $display("FAIL midrst_pre_cnt: got %0d want 1", a_cnt); end
        rstn = 1'b0;
        #1;
        total++; if (a_ready !== 2'b11) begin bad++; $display("FAIL midrst_ready: got %b want 11", a_ready); end
        total++; if (a_cnt !== 32'd0) begin bad++; $display("FAIL midrst_cnt: got %0d want 0", a_cnt); end
        total++; if (a_credit !== 2'b00) begin bad++; $display("FAIL midrst_credit: got %b want 00", a_credit); end
        a_valid = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        seen = 0;
        for (int p = 0; p < 16; p++) begin
            if (a_credit !== 2'b00) seen++;
            tick();
        end
        total++; if (seen != 0) begin bad++; $display("FAIL midrst_discard: got %0d credits want 0", seen); end
        total++; if (a_cnt !== 32'd0) begin bad++; $display("FAIL midrst_post_cnt: got %0d want 0", a_cnt); end
    endtask

    task automatic test_fill;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            a_valid = 1'b1; a_vc = 1'b0; a_data = 32'h200 + k;
            tick();
            if (k == 3) begin
                total++; if (a_ready !== 2'b10) begin bad++; $display("FAIL fill_ready_after4: got %b want 10", a_ready); end
                total++; if (a_drop !== 1'b0) begin bad++; $display("FAIL fill_drop_after4: got %b want 0", a_drop); end
            end
        end
        a_valid = 1'b0;
        total++; if (a_drop !== 1'b1) begin bad++; $display("FAIL fill_drop_after5: got %b want 1", a_drop); end
        repeat (9) tick();
        total++; if (a_credit !== 2'b01) begin bad++; $display("FAIL fill_credit_ph14: got %b want 01", a_credit); end
        total++; if (a_ready !== 2'b10) begin bad++; $display("FAIL fill_ready_pop_cycle: got %b want 10", a_ready); end
        a_valid = 1'b1; a_vc = 1'b0; a_data = 32'h2FF;
        tick();
        a_valid = 1'b0;
        total++; if (a_ready !== 2'b11) begin bad++; $display("FAIL fill_push_on_full_pop: got %b want 11", a_ready); end
        total++; if (a_credit !== 2'b01) begin bad++; $display("FAIL fill_credit_ph15: got %b want 01", a_credit); end
        tick();
        total++; if (a_cnt !== 32'd2) begin bad++; $display("FAIL fill_cnt: got %0d want 2", a_cnt); end
        total++; if (a_drop !== 1'b1) begin bad++; $display("FAIL fill_drop_sticky: got %b want 1", a_drop); end
    endtask

    task automatic test_bad_vc;
        do_reset();
        b_valid = 1'b1; b_vc = 2'd2; b_data = 32'h300;
        tick();
        total++; if (b_credit !== 3'b100) begin bad++; $display("FAIL badvc_good_credit: got %b want 100", b_credit); end
        total++; if (b_drop !== 1'b0) begin bad++; $display("FAIL badvc_good_drop: got %b want 0", b_drop); end
        b_vc = 2'd3; b_data = 32'h301;
        tick();
        b_valid = 1'b0;
        total++; if (b_drop !== 1'b1) begin bad++; $display("FAIL badvc_drop: got %b want 1", b_drop); end
        total++; if (b_credit !== 3'b000) begin bad++; $display("FAIL badvc_credit: got %b want 000", b_credit); end
        total++; if (b_ready !== 3'b111) begin bad++; $display("FAIL badvc_ready: got %b want 111", b_ready); end
        tick();
        total++; if (b_credit !== 3'b000) begin bad++; $display("FAIL badvc_credit_late: got %b want 000", b_credit); end
        total++; if (b_cnt !== 32'd1) begin bad++; $display("FAIL badvc_cnt: got %0d want 1", b_cnt); end
    endtask

    // Drain every cycle: each flit pops the cycle after its push, including
    // a push and pop on the same VC in one cycle.
    task automatic test_back_to_back;
        logic [1:0] vcs [5];
        logic [2:0] expv;
        do_reset();
        vcs[0] = 2'd0; vcs[1] = 2'd2; vcs[2] = 2'd1; vcs[3] = 2'd1; vcs[4] = 2'd0;
        exp_q_b.push_back(3'b001); exp_q_b.push_back(3'b100); exp_q_b.push_back(3'b010);
        exp_q_b.push_back(3'b010); exp_q_b.push_back(3'b001); exp_q_b.push_back(3'b000);
        for (int k = 0; k < 6; k++) begin
            b_valid = (k < 5);
            b_vc    = (k < 5) ? vcs[k] : 2'd0;
            b_data  = 32'h400 + k;
            tick();
            expv = exp_q_b.pop_front();
            total++; if (b_credit !== expv) begin bad++; $display("FAIL b2b_credit[%0d]: got %b want %b", k, b_credit, expv); end
        end
        b_valid = 1'b0;
        total++; if (b_cnt !== 32'd5) begin bad++; $display("FAIL b2b_cnt: got %0d want 5", b_cnt); end
    endtask

    // Two flits per VC, arrival order VC1 first; pointer starts at VC0.
    task automatic test_fairness;
        logic [1:0] expv;
        do_reset();
        exp_q_a.push_back(2'b01); exp_q_a.push_back(2'b10);
        exp_q_a.push_back(2'b01); exp_q_a.push_back(2'b10);
        for (int g = 0; g < 48; g++) begin
            a_valid = (g < 4);
            a_vc    = (g < 2) ? 1'b1 : 1'b0;
            a_data  = 32'h500 + g;
            expv    = 2'b00;
            if ((g % 16) >= 14 && exp_q_a.size() > 0) expv = exp_q_a.pop_front();
            total++; if (a_credit !== expv) begin bad++; $display("FAIL fair_credit[g=%0d]: got %b want %b", g, a_credit, expv); end
            tick();
        end
        a_valid = 1'b0;
        total++; if (a_cnt !== 32'd4) begin bad++; $display("FAIL fair_cnt: got %0d want 4", a_cnt); end
    endtask

    // 10 flits, two pops per 16-cycle period; done rises with the 10th pop.
    task automatic test_completion;
        int wrong;
        logic [1:0] expv;
        do_reset();
        wrong = 0;
        for (int g = 0; g < 80; g++) begin
            a_valid = (g < 8) || (g == 16) || (g == 17);
            a_vc    = ((g >= 4 && g < 8) || g == 17) ? 1'b1 : 1'b0;
            a_data  = 32'h600 + g;
            expv    = ((g % 16) == 14) ? 2'b01 : (((g % 16) == 15) ? 2'b10 : 2'b00);
            if (a_credit !== expv) wrong++;
            if (g == 79) begin
                total++; if (a_cnt !== 32'd9) begin bad++; $display("FAIL done_cnt_before: got %0d want 9", a_cnt); end
                total++; if (a_done !== 1'b0) begin bad++; $display("FAIL done_early: got %b want 0", a_done); end
            end
            tick();
        end
        a_valid = 1'b0;
        total++; if (wrong != 0) begin bad++; $display("FAIL done_credit_pattern: got %0d wrong cycles want 0", wrong); end
        total++; if (a_cnt !== 32'd10) begin bad++; $display("FAIL done_cnt_target: got %0d want 10", a_cnt); end
        total++; if (a_done !== 1'b1) begin bad++; $display("FAIL done_rise: got %b want 1", a_done); end
        total++; if (a_drop !== 1'b0) begin bad++; $display("FAIL done_no_drop: got %b want 0", a_drop); end
        repeat (16) tick();
        total++; if (a_done !== 1'b1) begin bad++; $display("FAIL done_sticky: got %b want 1", a_done); end
        total++; if (a_cnt !== 32'd10) begin bad++; $display("FAIL done_cnt_hold: got %0d want 10", a_cnt); end
    endtask

    // Test sequence and final report.
    initial begin
        total = 0;
        bad   = 0;
        rstn  = 1'b0;
        a_valid = 1'b0; a_vc = '0; a_data = '0;
        b_valid = 1'b0; b_vc = '0; b_data = '0;
        test_reset_values();
        test_single_flit();
        test_reset_mid_burst();
        test_fill();
        test_bad_vc();
        test_back_to_back();
        test_fairness();
        test_completion();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
